// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the UART transmit engine
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } parity_mode_e;

  // Character length code 00..11 maps to 5..8 data bits.
  function automatic logic [3:0] data_len(input logic [1:0] code);
    return 4'd5 + {2'b00, code};
  endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// rtl/uart_tx_frame_if.sv - character handshake, frame configuration and line status bundle
interface uart_tx_frame_if #(
  parameter int DIV_W  = 16,
  parameter int DATA_W = 8
);
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] tx_data;
  logic [1:0]        data_bits;
  logic [1:0]        parity_mode;
  logic              stop2;
  logic [DIV_W-1:0]  baud_div;
  logic              tx_out;
  logic              busy;
  logic              frame_done;

  modport master (
    output tx_valid, tx_data, data_bits, parity_mode, stop2, baud_div,
    input  tx_ready, tx_out, busy, frame_done
  );

  modport slave (
    input  tx_valid, tx_data, data_bits, parity_mode, stop2, baud_div,
    output tx_ready, tx_out, busy, frame_done
  );
endinterface

// File: rtl/uart_baud_cnt.sv
// rtl/uart_baud_cnt.sv - loadable bit-period down-counter, tick while the count is zero
module uart_baud_cnt #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             en,
  input  logic [DIV_W-1:0] load_val,
  output logic [DIV_W-1:0] count,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - DIV_W'(1);
    end
  end

  assign count = cnt;
  assign tick  = (cnt == '0);

endmodule

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - UART frame sequencer: start, 5-8 data bits LSB first, optional parity, 1-2 stop bits
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DIV_W  = 16,
  parameter int DATA_W = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  uart_tx_frame_if.slave bus
);

  uart_state_e       state;
  logic [DATA_W-1:0] shift_r;
  logic [2:0]        bit_idx;
  logic [2:0]        last_idx_r;
  parity_mode_e      par_mode_r;
  logic              stop2_r;
  logic              stop_idx;
  logic [DIV_W-1:0]  baud_r;
  logic              par_acc;
  logic              tx_out_r;
  logic              ready_r;
  logic              busy_r;
  logic              done_r;

  logic              accept;
  logic              baud_load;
  logic              baud_en;
  logic [DIV_W-1:0]  baud_val;
  logic [DIV_W-1:0]  baud_count;
  logic              tick;
  logic              par_en;
  logic              baud_zero;
  logic              last_stop;

  // ready_r is high exactly in IDLE, so accept never loops back through tx_valid.
  assign accept    = ready_r && bus.tx_valid;
  assign baud_load = accept || ((state != IDLE) && tick);
  assign baud_en   = (state != IDLE);
  assign baud_val  = accept ? bus.baud_div : baud_r;
  assign par_en    = (par_mode_r == PAR_EVEN) || (par_mode_r == PAR_ODD);
  assign baud_zero = (baud_r == '0);
  assign last_stop = (stop_idx == stop2_r);

  uart_baud_cnt #(.DIV_W(DIV_W)) u_baud_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (baud_load),
    .en       (baud_en),
    .load_val (baud_val),
    .count    (baud_count),
    .tick     (tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      tx_out_r   <= 1'b1;
      ready_r    <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      shift_r    <= '0;
      bit_idx    <= '0;
      last_idx_r <= '0;
      par_mode_r <= PAR_NONE;
      stop2_r    <= 1'b0;
      stop_idx   <= 1'b0;
      baud_r     <= '0;
      par_acc    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          tx_out_r <= 1'b1;
          if (accept) begin
            state      <= START;
            tx_out_r   <= 1'b0;
            ready_r    <= 1'b0;
            busy_r     <= 1'b1;
            shift_r    <= bus.tx_data;
            last_idx_r <= 3'(data_len(bus.data_bits) - 4'd1);
            par_mode_r <= parity_mode_e'(bus.parity_mode);
            stop2_r    <= bus.stop2;
            baud_r     <= bus.baud_div;
            // Odd parity is the even XOR inverted, so seed the accumulator with 1.
            par_acc    <= (parity_mode_e'(bus.parity_mode) == PAR_ODD);
          end
        end

        START: begin
          if (tick) begin
            state    <= DATA;
            bit_idx  <= '0;
            tx_out_r <= shift_r[0];
            par_acc  <= par_acc ^ shift_r[0];
            shift_r  <= shift_r >> 1;
          end
        end

        DATA: begin
          if (tick) begin
            if (bit_idx == last_idx_r) begin
              if (par_en) begin
                state    <= PARITY;
                tx_out_r <= par_acc;
              end else begin
                state    <= STOP;
                tx_out_r <= 1'b1;
                stop_idx <= 1'b0;
                done_r   <= !stop2_r && baud_zero;
              end
            end else begin
              bit_idx  <= bit_idx + 3'd1;
              tx_out_r <= shift_r[0];
              par_acc  <= par_acc ^ shift_r[0];
              shift_r  <= shift_r >> 1;
            end
          end
        end

        PARITY: begin
          if (tick) begin
            state    <= STOP;
            tx_out_r <= 1'b1;
            stop_idx <= 1'b0;
            done_r   <= !stop2_r && baud_zero;
          end
        end

        STOP: begin
          tx_out_r <= 1'b1;
          if (tick) begin
            if (last_stop) begin
              state   <= IDLE;
              ready_r <= 1'b1;
              busy_r  <= 1'b0;
            end else begin
              stop_idx <= 1'b1;
              done_r   <= baud_zero;
            end
          end else begin
            // Registered pulse: raise it on the edge that enters the final clock.
            done_r <= last_stop && (baud_count == DIV_W'(1));
          end
        end

        default: begin
          state    <= IDLE;
          tx_out_r <= 1'b1;
          ready_r  <= 1'b1;
          busy_r   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tx_out     = tx_out_r;
  assign bus.tx_ready   = ready_r;
  assign bus.busy       = busy_r;
  assign bus.frame_done = done_r;

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb/tb_uart_tx_frame.sv - directed self-checking bench for uart_tx_frame
module tb_uart_tx_frame;

  logic clk;
  logic reset_n;
  int   tests_run;
  int   tests_failed;

  uart_tx_frame_if #(.DIV_W(16), .DATA_W(8)) bus ();

  uart_tx_frame #(.DIV_W(16), .DATA_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Offers one character, records tx_out per clock (index 0 = first clock after accept)
  // until frame_done, then advances one more clock.
  task automatic run_frame(input logic [7:0] d, input logic [1:0] nb, input logic [1:0] pm,
                           input logic s2, input logic [15:0] bd,
                           output logic [127:0] line, output int done_at);
    line    = '0;
    done_at = 0;
    bus.tx_data     = d;
    bus.data_bits   = nb;
    bus.parity_mode = pm;
    bus.stop2       = s2;
    bus.baud_div    = bd;
    bus.tx_valid    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.tx_valid = 1'b0;
    for (int i = 0; i < 120 && done_at == 0; i++) begin
      if (i > 0) @(negedge clk);
      line[i] = bus.tx_out;
      if (bus.frame_done) done_at = i + 1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n         = 1'b0;
    bus.tx_valid    = 1'b0;
    bus.tx_data     = 8'h00;
    bus.data_bits   = 2'b11;
    bus.parity_mode = 2'b00;
    bus.stop2       = 1'b0;
    bus.baud_div    = 16'd0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (bus.tx_out !== 1'b1) begin tests_failed++; $display("FAIL reset_tx_out: got %b expected 1", bus.tx_out); end
    tests_run++;
    if (bus.tx_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_tx_ready: got %b expected 1", bus.tx_ready); end
    tests_run++;
    if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    tests_run++;
    if (bus.frame_done !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_done: got %b expected 0", bus.frame_done); end
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    tests_run++;
    if (bus.tx_out !== 1'b1) begin tests_failed++; $display("FAIL idle_tx_out: got %b expected 1", bus.tx_out); end
    tests_run++;
    if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL idle_busy: got %b expected 0", bus.busy); end
  endtask

  task automatic test_8n1_min_period();
    logic [127:0] line;
    int done_at;
    run_frame(8'h55, 2'b11, 2'b00, 1'b0, 16'd0, line, done_at);
    tests_run++;
    if (line !== 128'h2AA) begin tests_failed++; $display("FAIL 8n1_line: got %h expected %h", line, 128'h2AA); end
    tests_run++;
    if (done_at !== 10) begin tests_failed++; $display("FAIL 8n1_done_clock: got %0d expected 10", done_at); end
    tests_run++;
    if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL 8n1_busy_after: got %b expected 0", bus.busy); end
    tests_run++;
    if (bus.tx_ready !== 1'b1) begin tests_failed++; $display("FAIL 8n1_ready_after: got %b expected 1", bus.tx_ready); end
    tests_run++;
    if (bus.frame_done !== 1'b0) begin tests_failed++; $display("FAIL 8n1_done_pulse_width: got %b expected 0", bus.frame_done); end
  endtask

  task automatic test_7e2_parity_mask();
    logic [127:0] line;
    logic [127:0] exp;
    logic [10:0]  bits;
    int done_at;
    bits = 11'b11010000010;
    exp  = '0;
    for (int i = 0; i < 44; i++) exp[i] = bits[i / 4];
    run_frame(8'hC1, 2'b10, 2'b01, 1'b1, 16'd3, line, done_at);
    tests_run++;
    if (line !== exp) begin tests_failed++; $display("FAIL 7e2_line: got %h expected %h", line, exp); end
    tests_run++;
    if (done_at !== 44) begin tests_failed++; $display("FAIL 7e2_done_clock: got %0d expected 44", done_at); end
    tests_run++;
    if (bus.tx_ready !== 1'b1) begin tests_failed++; $display("FAIL 7e2_ready_after: got %b expected 1", bus.tx_ready); end
  endtask

  task automatic test_5o1_short_odd();
    logic [127:0] line;
    logic [127:0] exp;
    logic [7:0]   bits;
    int done_at;
    bits = 8'b10111110;
    exp  = '0;
    for (int i = 0; i < 16; i++) exp[i] = bits[i / 2];
    run_frame(8'hFF, 2'b00, 2'b10, 1'b0, 16'd1, line, done_at);
    tests_run++;
    if (line !== exp) begin tests_failed++; $display("FAIL 5o1_line: got %h expected %h", line, exp); end
    tests_run++;
    if (done_at !== 16) begin tests_failed++; $display("FAIL 5o1_done_clock: got %0d expected 16", done_at); end
    run_frame(8'h1F, 2'b00, 2'b10, 1'b0, 16'd1, line, done_at);
    tests_run++;
    if (line !== exp) begin tests_failed++; $display("FAIL 5o1_masked_line: got %h expected %h", line, exp); end
    tests_run++;
    if (done_at !== 16) begin tests_failed++; $display("FAIL 5o1_masked_done_clock: got %0d expected 16", done_at); end
  endtask

  task automatic test_back_to_back();
    logic [40:0] line;
    logic [40:0] exp;
    logic [40:0] done_v;
    logic [40:0] exp_done;
    logic [9:0]  f1;
    logic [9:0]  f2;
    logic        rdy21;
    logic        busy33;
    f1 = 10'b1101001010;
    f2 = 10'b1001111000;
    exp = '0;
    exp_done = '0;
    line = '0;
    done_v = '0;
    rdy21 = 1'b0;
    busy33 = 1'b1;
    for (int i = 1; i <= 20; i++) exp[i] = f1[(i - 1) / 2];
    exp[21] = 1'b1;
    for (int i = 22; i <= 31; i++) exp[i] = f2[i - 22];
    exp[32] = 1'b1;
    exp[33] = 1'b1;
    exp_done[20] = 1'b1;
    exp_done[31] = 1'b1;
    bus.tx_data     = 8'hA5;
    bus.data_bits   = 2'b11;
    bus.parity_mode = 2'b00;
    bus.stop2       = 1'b0;
    bus.baud_div    = 16'd1;
    bus.tx_valid    = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 33; i++) begin
      @(negedge clk);
      line[i]   = bus.tx_out;
      done_v[i] = bus.frame_done;
      if (i == 21) rdy21 = bus.tx_ready;
      if (i == 33) busy33 = bus.busy;
      if (i == 3) begin
        bus.tx_data  = 8'h3C;
        bus.baud_div = 16'd0;
      end
      if (i == 22) bus.tx_valid = 1'b0;
    end
    tests_run++;
    if (line !== exp) begin tests_failed++; $display("FAIL b2b_line: got %h expected %h", line, exp); end
    tests_run++;
    if (done_v !== exp_done) begin tests_failed++; $display("FAIL b2b_frame_done: got %h expected %h", done_v, exp_done); end
    tests_run++;
    if (rdy21 !== 1'b1) begin tests_failed++; $display("FAIL b2b_idle_ready: got %b expected 1", rdy21); end
    tests_run++;
    if (busy33 !== 1'b0) begin tests_failed++; $display("FAIL b2b_no_third_frame: got %b expected 0", busy33); end
  endtask

  task automatic test_reset_mid_frame();
    logic [127:0] line;
    int done_at;
    bus.tx_data     = 8'h00;
    bus.data_bits   = 2'b11;
    bus.parity_mode = 2'b00;
    bus.stop2       = 1'b0;
    bus.baud_div    = 16'd3;
    bus.tx_valid    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.tx_valid = 1'b0;
    repeat (17) @(negedge clk);
    tests_run++;
    if (bus.tx_out !== 1'b0) begin tests_failed++; $display("FAIL midrst_data_bit3: got %b expected 0", bus.tx_out); end
    #1 reset_n = 1'b0;
    #1;
    tests_run++;
    if (bus.tx_out !== 1'b1) begin tests_failed++; $display("FAIL midrst_async_tx_out: got %b expected 1", bus.tx_out); end
    tests_run++;
    if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
    tests_run++;
    if (bus.tx_ready !== 1'b1) begin tests_failed++; $display("FAIL midrst_ready: got %b expected 1", bus.tx_ready); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_frame(8'h96, 2'b11, 2'b00, 1'b0, 16'd0, line, done_at);
    tests_run++;
    if (line !== 128'h32C) begin tests_failed++; $display("FAIL midrst_next_line: got %h expected %h", line, 128'h32C); end
    tests_run++;
    if (done_at !== 10) begin tests_failed++; $display("FAIL midrst_next_done_clock: got %0d expected 10", done_at); end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_8n1_min_period();
    test_7e2_parity_mask();
    test_5o1_short_odd();
    test_back_to_back();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
